apply_deltas_list: RTL

- Consumer end of the calibration delta path: holds a 16-point calibration table (C values at fixed positions Mk) plus the 15 segment slopes produced by the delta-list generator.
- Maps a streamed input x to a piecewise-linear output y = Ck + delta_k*(x-Mk).
- Sits downstream of the delta generator. Takes a new table on each rising edge of cal_valid.
- Processes samples through a 3-stage valid/ready pipeline.

---
 rtl/apply_deltas_list_pkg.sv | 36 +++
 rtl/apply_deltas_list_segment_find.sv | 38 +++
 rtl/apply_deltas_list.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/apply_deltas_list_pkg.sv
// apply_deltas_list_pkg
//   Constants and types shared by the calibration delta consumer and its
//   segment finder.
//   - default data / fixed-point widths (DSIZE, DT_I, DT_D, DT_W)
//   - table geometry: NPTS points, NSEG segments
//   - control state encoding
//   - default breakpoint list M_LIST_DEF (Mk = 16*(k+1), M00 in the LSBs),
//     the same list the delta generator side uses
package apply_deltas_list_pkg;

  localparam int unsigned DSIZE_DEF = 16;
  localparam int unsigned DT_I_DEF  = 8;
  localparam int unsigned DT_D_DEF  = 4;
  localparam int unsigned DT_W      = DT_I_DEF + DT_D_DEF;

  localparam int unsigned NPTS = 16;
  localparam int unsigned NSEG = 15;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_e;

  function automatic logic [NPTS*DSIZE_DEF-1:0] default_m_list();
    logic [NPTS*DSIZE_DEF-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < NPTS; k++) begin
      m[k*DSIZE_DEF +: DSIZE_DEF] = DSIZE_DEF'(16 * (k + 1));
    end
    return m;
  endfunction

  localparam logic [NPTS*DSIZE_DEF-1:0] M_LIST_DEF = default_m_list();

endpackage

// File: rtl/apply_deltas_list_segment_find.sv
// pwl_segment_find
//   Combinational priority compare of a sample position against the
//   breakpoint list.
//   Ports:
//     x_i        sample position
//     seg_o      largest k in 0..NSEG-1 with x >= Mk (0 when below M00)
//     mk_o       breakpoint Mk for the selected segment
//     clip_lo_o  x below the first breakpoint
//     clip_hi_o  x at or above the last breakpoint
module pwl_segment_find
  import apply_deltas_list_pkg::*;
#(
  parameter int unsigned             DSIZE  = DSIZE_DEF,
  parameter logic [NPTS*DSIZE-1:0]   M_LIST = M_LIST_DEF
) (
  input  logic [DSIZE-1:0] x_i,
  output logic [3:0]       seg_o,
  output logic [DSIZE-1:0] mk_o,
  output logic             clip_lo_o,
  output logic             clip_hi_o
);

  // Breakpoints are strictly increasing, so the last match in an ascending
  // scan is the largest qualifying index.
  always_comb begin
    seg_o = '0;
    mk_o  = M_LIST[DSIZE-1:0];
    for (int unsigned i = 1; i < NSEG; i++) begin
      if (x_i >= M_LIST[i*DSIZE +: DSIZE]) begin
        seg_o = 4'(i);
        mk_o  = M_LIST[i*DSIZE +: DSIZE];
      end
    end
    clip_lo_o = (x_i <  M_LIST[DSIZE-1:0]);
    clip_hi_o = (x_i >= M_LIST[(NPTS-1)*DSIZE +: DSIZE]);
  end

endmodule

// File: rtl/apply_deltas_list.sv
// apply_deltas_list
//   Consumer end of the calibration delta path. Holds a 16-point table
//   (C values at fixed breakpoints Mk) and 15 segment slopes, and maps a
//   streamed x to y = Ck + delta_k*(x-Mk) through a 3-stage pipeline.
//   Ports:
//     clock, rst_n          clock, asynchronous active-low reset
//     cal_valid             table valid; a rising edge loads c_list/delta_list
//     c_list, delta_list    packed table (entry 0 in the LSBs)
//     table_ok              a table has been loaded
//     in_valid/in_ready/x_in        sample input handshake
//     out_valid/out_ready/y_out     result output handshake
//     seg_out, clip_lo, clip_hi     segment used and clip indications
module apply_deltas_list
  import apply_deltas_list_pkg::*;
#(
  parameter int unsigned           DSIZE  = DSIZE_DEF,
  parameter int unsigned           DT_I   = DT_I_DEF,
  parameter int unsigned           DT_D   = DT_D_DEF,
  parameter logic [NPTS*DSIZE-1:0] M_LIST = M_LIST_DEF
) (
  input  logic                           clock,
  input  logic                           rst_n,
  input  logic                           cal_valid,
  input  logic [NPTS*DSIZE-1:0]          c_list,
  input  logic [NSEG*(DT_I+DT_D)-1:0]    delta_list,
  output logic                           table_ok,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DSIZE-1:0]               x_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DSIZE-1:0]               y_out,
  output logic [3:0]                     seg_out,
  output logic                           clip_lo,
  output logic                           clip_hi
);

  localparam int unsigned DW = DT_I + DT_D;      // delta width
  localparam int unsigned PW = DSIZE + DW;       // product width
  localparam int unsigned SW = DSIZE + DT_I + 1; // sum width incl. carry

  // ---------------- control ----------------
  state_e state_q, state_d;
  logic   cal_d_q;
  logic   table_ok_q;
  logic   rise;
  logic   stall;
  logic   accept;

  // ---------------- table ----------------
  logic [NPTS*DSIZE-1:0] c_q;
  logic [NSEG*DW-1:0]    d_q;

  // ---------------- stage 1 ----------------
  logic             v1_q;
  logic [3:0]       seg1_q;
  logic [DSIZE-1:0] dx1_q;
  logic [DSIZE-1:0] ck1_q;
  logic [DW-1:0]    dk1_q;
  logic             lo1_q, hi1_q;

  // ---------------- stage 2 ----------------
  logic             v2_q;
  logic [3:0]       seg2_q;
  logic [PW-1:0]    p2_q;
  logic [DSIZE-1:0] ck2_q;
  logic             lo2_q, hi2_q;

  // ---------------- stage 3 ----------------
  logic             v3_q;
  logic [3:0]       seg3_q;
  logic [DSIZE-1:0] y3_q;
  logic             lo3_q, hi3_q;

  // ---------------- combinational helpers ----------------
  logic [3:0]       seg_f;
  logic [DSIZE-1:0] mk_f;
  logic             lo_f, hi_f;
  logic [DSIZE-1:0] ck_sel;
  logic [DW-1:0]    dk_sel;
  logic [PW-1:0]    p_calc;
  logic [SW-1:0]    sum3;
  logic [DSIZE-1:0] y_calc;

  assign rise   = cal_valid & ~cal_d_q;
  assign stall  = v3_q & ~out_ready;
  assign accept = in_valid & in_ready;

  // FSM next state and in_ready
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (rise) state_d = LOAD;
      end
      LOAD: begin
        state_d = RUN;
      end
      RUN: begin
        in_ready = ~stall;
        if (rise) state_d = LOAD;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      cal_d_q    <= 1'b0;
      table_ok_q <= 1'b0;
      c_q        <= '0;
      d_q        <= '0;
    end else begin
      state_q <= state_d;
      cal_d_q <= cal_valid;
      if (state_q == LOAD) begin
        c_q        <= c_list;
        d_q        <= delta_list;
        table_ok_q <= 1'b1;
      end
    end
  end

  // Stage 1 is the only reader of the table registers; later stages carry
  // their own operands so a reload never disturbs samples in flight.
  pwl_segment_find #(
    .DSIZE  (DSIZE),
    .M_LIST (M_LIST)
  ) u_find (
    .x_i       (x_in),
    .seg_o     (seg_f),
    .mk_o      (mk_f),
    .clip_lo_o (lo_f),
    .clip_hi_o (hi_f)
  );

  // Above the last breakpoint the result is C15, not C14.
  assign ck_sel = hi_f ? c_q[(NPTS-1)*DSIZE +: DSIZE] : c_q[seg_f*DSIZE +: DSIZE];
  assign dk_sel = d_q[seg_f*DW +: DW];

  assign p_calc = PW'(dk1_q) * PW'(dx1_q);

  // Only the integer part of the product is added; a carry beyond DSIZE
  // saturates the result.
  assign sum3   = SW'(ck2_q) + SW'(p2_q >> DT_D);
  assign y_calc = (|sum3[SW-1:DSIZE]) ? '1 : sum3[DSIZE-1:0];

  // Global stall: every stage holds while the output is blocked.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      seg1_q <= '0;
      dx1_q  <= '0;
      ck1_q  <= '0;
      dk1_q  <= '0;
      lo1_q  <= 1'b0;
      hi1_q  <= 1'b0;
      v2_q   <= 1'b0;
      seg2_q <= '0;
      p2_q   <= '0;
      ck2_q  <= '0;
      lo2_q  <= 1'b0;
      hi2_q  <= 1'b0;
      v3_q   <= 1'b0;
      seg3_q <= '0;
      y3_q   <= '0;
      lo3_q  <= 1'b0;
      hi3_q  <= 1'b0;
    end else if (!stall) begin
      v1_q <= accept;
      if (accept) begin
        seg1_q <= seg_f;
        dx1_q  <= x_in - mk_f;
        ck1_q  <= ck_sel;
        dk1_q  <= dk_sel;
        lo1_q  <= lo_f;
        hi1_q  <= hi_f;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        seg2_q <= seg1_q;
        p2_q   <= p_calc;
        ck2_q  <= ck1_q;
        lo2_q  <= lo1_q;
        hi2_q  <= hi1_q;
      end
      v3_q <= v2_q;
      if (v2_q) begin
        seg3_q <= seg2_q;
        y3_q   <= (lo2_q | hi2_q) ? ck2_q : y_calc;
        lo3_q  <= lo2_q;
        hi3_q  <= hi2_q;
      end
    end
  end

  assign table_ok  = table_ok_q;
  assign out_valid = v3_q;
  assign y_out     = y3_q;
  assign seg_out   = seg3_q;
  assign clip_lo   = lo3_q;
  assign clip_hi   = hi3_q;

endmodule
